// File: rtl/jtag_shift_master.sv
// jtag_shift_master: fabric-side JTAG engine. It drives TCK/TMS/TDI for a
// TAP and samples TDO, so on-chip logic can reach the TAP with no external probe.
// One command shifts 1..32 TMS/TDI bit pairs LSB-first. The TDO bits sampled
// on each rising TCK edge come back as a 32-bit word.
//
// Ports:
//   CLK50MHZ   system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  engine idle, command accepted on cmd_valid
//   cmd_len    bits to shift minus one
//   cmd_tms    TMS sequence, bit 0 first
//   cmd_tdi    TDI sequence, bit 0 first
//   rsp_valid  one-cycle pulse when rsp_tdo is updated
//   rsp_tdo    captured TDO; bit i is sampled at the rising TCK of shift bit i
//   busy       command in progress
//   jtag_tck   TCK to the TAP
//   jtag_tms   TMS to the TAP
//   jtag_tdi   TDI to the TAP
//   jtag_tdo   TDO from the TAP (asynchronous, pulled up on the board)

module jtag_shift_master #(
  parameter int unsigned HALF_PERIOD = 4  // CLK50MHZ cycles per TCK half-period, 3..255
) (
  input  logic        CLK50MHZ,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  output logic [31:0] rsp_tdo,
  output logic        busy,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
);

  localparam logic [7:0] DivLast = 8'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] tms_seq_q, tms_seq_d;
  logic [31:0] tdi_seq_q, tdi_seq_d;
  logic [31:0] cap_q, cap_d;
  logic        tck_q, tck_d;
  logic        tms_out_q, tms_out_d;
  logic        tdi_out_q, tdi_out_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_tdo_q, rsp_tdo_d;

  logic        tdo_meta_q, tdo_sync_q;
  logic        div_done;
  logic [4:0]  bit_nxt;

  // TDO is asynchronous to CLK50MHZ. Both synchronizer stages reset to the
  // idle (pulled-up) level.
  always_ff @(posedge CLK50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      tdo_meta_q <= 1'b1;
      tdo_sync_q <= 1'b1;
    end else begin
      tdo_meta_q <= jtag_tdo;
      tdo_sync_q <= tdo_meta_q;
    end
  end

  assign div_done = (div_q == DivLast);
  assign bit_nxt  = bit_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    len_d       = len_q;
    tms_seq_d   = tms_seq_q;
    tdi_seq_d   = tdi_seq_q;
    cap_d       = cap_q;
    tck_d       = tck_q;
    tms_out_d   = tms_out_q;
    tdi_out_d   = tdi_out_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tdo_d   = rsp_tdo_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          len_d     = cmd_len;
          tms_seq_d = cmd_tms;
          tdi_seq_d = cmd_tdi;
          // Bit 0 goes out at the handshake edge and gets a full half-period
          // of setup before the first rising TCK.
          tms_out_d = cmd_tms[0];
          tdi_out_d = cmd_tdi[0];
          bit_d     = '0;
          div_d     = '0;
          // Cleared here so that bits above cmd_len come back as zero.
          cap_d     = '0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = StLow;
        end
      end

      StLow: begin
        if (div_done) begin
          tck_d        = 1'b1;
          cap_d[bit_q] = tdo_sync_q;
          div_d        = '0;
          state_d      = StHigh;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StHigh: begin
        if (div_done) begin
          tck_d = 1'b0;
          div_d = '0;
          if (bit_q == len_q) begin
            rsp_valid_d = 1'b1;
            rsp_tdo_d   = cap_q;
            state_d     = StDone;
          end else begin
            // The next bit changes at the falling TCK edge, so the TAP sees it
            // stable for a whole half-period before it samples.
            bit_d     = bit_nxt;
            tms_out_d = tms_seq_q[bit_nxt];
            tdi_out_d = tdi_seq_q[bit_nxt];
            state_d   = StLow;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      StDone: begin
        rsp_valid_d = 1'b0;
        ready_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      tms_seq_q   <= '0;
      tdi_seq_q   <= '0;
      cap_q       <= '0;
      tck_q       <= 1'b0;
      tms_out_q   <= 1'b1;
      tdi_out_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      tms_seq_q   <= tms_seq_d;
      tdi_seq_q   <= tdi_seq_d;
      cap_q       <= cap_d;
      tck_q       <= tck_d;
      tms_out_q   <= tms_out_d;
      tdi_out_q   <= tdi_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_out_q;
  assign jtag_tdi  = tdi_out_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// tb_jtag_shift_master: self-checking bench for jtag_shift_master.
// TDO comes from one of four sources: board pull-up, loopback of TDI, a
// behavioural TAP with an IDCODE register, or a random per-bit pattern.
// A negedge monitor logs TMS/TDI and the cycle of every rising TCK edge.

module tb_jtag_shift_master;

  localparam int          HP     = 4;
  localparam int          LogSz  = 4096;
  localparam logic [31:0] IdCode = 32'h1E200A6D;

  logic        CLK50MHZ  = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_len   = '0;
  logic [31:0] cmd_tms   = '0;
  logic [31:0] cmd_tdi   = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_tdo;
  logic        busy;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo;

  jtag_shift_master #(
    .HALF_PERIOD(HP)
  ) dut (
    .CLK50MHZ (CLK50MHZ),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_tms  (cmd_tms),
    .cmd_tdi  (cmd_tdi),
    .rsp_valid(rsp_valid),
    .rsp_tdo  (rsp_tdo),
    .busy     (busy),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (jtag_tdo)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  // Edge counter: at a negedge, cyc is the index of the last rising CLK edge.
  int cyc = 0;
  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int   rises_total = 0;
  int   rsp_count   = 0;
  int   stable_viol = 0;
  logic tms_log [LogSz];
  logic tdi_log [LogSz];
  int   rise_cyc [LogSz];
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_hs = 1'b0, p_rst = 1'b0, p_rv = 1'b0;

  always @(negedge CLK50MHZ) begin
    if (jtag_tck && !p_tck) begin
      tms_log[rises_total % LogSz]  <= jtag_tms;
      tdi_log[rises_total % LogSz]  <= jtag_tdi;
      rise_cyc[rises_total % LogSz] <= cyc;
      rises_total <= rises_total + 1;
    end
    if (rsp_valid && !p_rv) rsp_count <= rsp_count + 1;
    // TMS/TDI may move only with a falling TCK or right after a handshake.
    if (rst_n && p_rst && ((jtag_tms != p_tms) || (jtag_tdi != p_tdi)) &&
        !(p_tck && !jtag_tck) && !p_hs)
      stable_viol <= stable_viol + 1;
    p_tck <= jtag_tck;
    p_tms <= jtag_tms;
    p_tdi <= jtag_tdi;
    p_hs  <= cmd_valid && cmd_ready;
    p_rst <= rst_n;
    p_rv  <= rsp_valid;
  end

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauseDr, TapEx2Dr, TapUpDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauseIr, TapEx2Ir, TapUpIr
  } tap_e;

  tap_e        tap_state = TapTlr;
  logic [31:0] tap_dr    = '0;
  logic        tap_tdo   = 1'b1;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TapTlr:     return tms ? TapTlr   : TapRti;
      TapRti:     return tms ? TapSelDr : TapRti;
      TapSelDr:   return tms ? TapSelIr : TapCapDr;
      TapCapDr:   return tms ? TapEx1Dr : TapShDr;
      TapShDr:    return tms ? TapEx1Dr : TapShDr;
      TapEx1Dr:   return tms ? TapUpDr  : TapPauseDr;
      TapPauseDr: return tms ? TapEx2Dr : TapPauseDr;
      TapEx2Dr:   return tms ? TapUpDr  : TapShDr;
      TapUpDr:    return tms ? TapSelDr : TapRti;
      TapSelIr:   return tms ? TapTlr   : TapCapIr;
      TapCapIr:   return tms ? TapEx1Ir : TapShIr;
      TapShIr:    return tms ? TapEx1Ir : TapShIr;
      TapEx1Ir:   return tms ? TapUpIr  : TapPauseIr;
      TapPauseIr: return tms ? TapEx2Ir : TapPauseIr;
      TapEx2Ir:   return tms ? TapUpIr  : TapShIr;
      default:    return tms ? TapSelDr : TapRti;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    if (tap_state == TapCapDr)     tap_dr <= IdCode;
    else if (tap_state == TapShDr) tap_dr <= {jtag_tdi, tap_dr[31:1]};
    tap_state <= tap_next(tap_state, jtag_tms);
  end

  always @(negedge jtag_tck) tap_tdo <= (tap_state == TapShDr) ? tap_dr[0] : 1'b1;

  // ---------------- TDO source select ----------------
  typedef enum logic [1:0] {SrcPullup, SrcLoop, SrcTap, SrcPat} src_e;
  src_e        src      = SrcPullup;
  logic [31:0] pat      = '0;
  int          pat_base = 0;
  logic [4:0]  pat_idx;

  assign pat_idx  = 5'(rises_total - pat_base);
  assign jtag_tdo = (src == SrcLoop) ? jtag_tdi :
                    (src == SrcTap)  ? tap_tdo  :
                    (src == SrcPat)  ? pat[pat_idx] : 1'b1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] len_mask(input logic [4:0] len);
    return 32'((64'd1 << (int'(len) + 1)) - 64'd1);
  endfunction

  // Expected response: bit i is whatever TDO the source presents for shift bit i.
  function automatic logic [31:0] model_tdo(input src_e s, input logic [4:0] len,
                                            input logic [31:0] tdi, input logic [31:0] p);
    case (s)
      SrcLoop: return tdi & len_mask(len);
      SrcPat:  return p & len_mask(len);
      default: return len_mask(len);
    endcase
  endfunction

  // Returns at the negedge just before the handshake edge.
  task automatic wait_hs(output int hs, output int base);
    int n = 0;
    @(negedge CLK50MHZ);
    while (!cmd_ready && n < 2000) begin
      @(negedge CLK50MHZ);
      n++;
    end
    if (!cmd_ready) check("hs_timeout", 32'(cmd_ready), 32'd1);
    hs       = cyc + 1;
    base     = rises_total;
    pat_base = rises_total;
  endtask

  task automatic wait_rsp(input string tag, output int r);
    int n = 0;
    @(negedge CLK50MHZ);
    while (!rsp_valid && n < 2 * HP * 34 + 20) begin
      @(negedge CLK50MHZ);
      n++;
    end
    if (!rsp_valid) check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    r = cyc;
  endtask

  task automatic send(input logic [4:0] len, input logic [31:0] tms, input logic [31:0] tdi,
                      output int hs, output int base);
    @(posedge CLK50MHZ);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    wait_hs(hs, base);
    @(posedge CLK50MHZ);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input logic [4:0] len, input logic [31:0] tms,
                           input logic [31:0] tdi, input logic [31:0] exp_tdo,
                           input int hs, input int base, input int r);
    int          n;
    int          on_time;
    logic [31:0] tms_w;
    logic [31:0] tdi_w;
    n       = int'(len) + 1;
    on_time = 0;
    tms_w   = '0;
    tdi_w   = '0;
    for (int i = 0; i < n; i++) begin
      int idx = (base + i) % LogSz;
      tms_w[i] = tms_log[idx];
      tdi_w[i] = tdi_log[idx];
      if (rise_cyc[idx] == hs + HP + 2 * HP * i) on_time++;
    end
    check({tag, "_tdo"}, rsp_tdo, exp_tdo);
    check({tag, "_latency"}, r - hs, 2 * HP * n);
    check({tag, "_tck_count"}, rises_total - base, n);
    check({tag, "_tck_timing"}, on_time, n);
    check({tag, "_tms_seq"}, tms_w, tms & len_mask(len));
    check({tag, "_tdi_seq"}, tdi_w, tdi & len_mask(len));
  endtask

  task automatic do_cmd(input string tag, input logic [4:0] len, input logic [31:0] tms,
                        input logic [31:0] tdi, input logic [31:0] exp_tdo);
    int hs, base, r;
    send(len, tms, tdi, hs, base);
    wait_rsp(tag, r);
    check_cmd(tag, len, tms, tdi, exp_tdo, hs, base, r);
    @(negedge CLK50MHZ);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_hold"}, rsp_tdo, exp_tdo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          hs, base, r, h2, b2, r2, cnt0, n;
    logic [4:0]  len;
    logic [31:0] tms, tdi, tms_b, tdi_b;

    repeat (3) @(posedge CLK50MHZ);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge CLK50MHZ);
    check("idle_tck", 32'(jtag_tck), 32'd0);
    check("idle_tms", 32'(jtag_tms), 32'd1);
    check("idle_tdi", 32'(jtag_tdi), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_tdo", rsp_tdo, 32'd0);
    check("idle_no_tck", rises_total, 32'd0);

    // Five ones reach Test-Logic-Reset from anywhere, the trailing zero enters RTI.
    src = SrcTap;
    do_cmd("tms_walk", 5'd5, 32'h1F, 32'h0, 32'h3F);
    check("tms_walk_tap_rti", 32'(tap_state), 32'(TapRti));

    src = SrcPullup;
    do_cmd("pullup8", 5'd7, 32'h0, 32'h80, 32'hFF);
    check("between_tck", 32'(jtag_tck), 32'd0);
    check("between_tms", 32'(jtag_tms), 32'd0);
    check("between_tdi", 32'(jtag_tdi), 32'd1);
    check("between_busy", 32'(busy), 32'd0);

    src = SrcTap;
    do_cmd("nav_shift_dr", 5'd3, 32'h2, 32'h0, 32'hF);
    check("nav_tap_shdr", 32'(tap_state), 32'(TapShDr));
    do_cmd("idcode", 5'd31, 32'h8000_0000, 32'h0, IdCode);
    check("idcode_tap_ex1dr", 32'(tap_state), 32'(TapEx1Dr));

    src = SrcLoop;
    do_cmd("loop32", 5'd31, 32'h0, 32'hA5A53C3C, 32'hA5A53C3C);

    // Two commands back-to-back with cmd_valid held high.
    tms   = $urandom;
    tdi   = $urandom;
    tms_b = $urandom;
    tdi_b = $urandom;
    @(posedge CLK50MHZ);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 5'd9;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    wait_hs(hs, base);
    @(posedge CLK50MHZ);
    #1;
    cmd_len = 5'd12;
    cmd_tms = tms_b;
    cmd_tdi = tdi_b;
    wait_rsp("queue1", r);
    check_cmd("queue1", 5'd9, tms, tdi, tdi & len_mask(5'd9), hs, base, r);
    wait_hs(h2, b2);
    check("queue_gap", h2 - r, 32'd2);
    check("queue1_pulse", 32'(rsp_valid), 32'd0);
    @(posedge CLK50MHZ);
    #1;
    cmd_valid = 1'b0;
    wait_rsp("queue2", r2);
    check_cmd("queue2", 5'd12, tms_b, tdi_b, tdi_b & len_mask(5'd12), h2, b2, r2);

    for (int k = 0; k < 20; k++) begin
      src = src_e'($urandom_range(0, 2) == 0 ? SrcPullup : ($urandom_range(0, 1) ? SrcLoop : SrcPat));
      len = 5'($urandom_range(0, 31));
      tms = $urandom;
      tdi = $urandom;
      pat = $urandom;
      do_cmd($sformatf("rnd%0d", k), len, tms, tdi, model_tdo(src, len, tdi, pat));
    end

    // Reset during the third TCK high phase of a 16-bit command. Bit 2 has
    // TMS=0 and TDI=1, so the reset values are visibly different.
    src  = SrcLoop;
    cnt0 = rsp_count;
    send(5'd15, 32'h0, 32'h0000FFFF, hs, base);
    n = 0;
    while ((rises_total - base) < 3 && n < 1000) begin
      @(negedge CLK50MHZ);
      n++;
    end
    check("rst_third_rise", 32'(jtag_tck), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tck", 32'(jtag_tck), 32'd0);
    check("rst_tms", 32'(jtag_tms), 32'd1);
    check("rst_tdi", 32'(jtag_tdi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_tdo", rsp_tdo, 32'd0);
    repeat (5) @(negedge CLK50MHZ);
    rst_n = 1'b1;
    repeat (2 * HP * 16 + 10) @(negedge CLK50MHZ);
    check("rst_no_rsp", rsp_count - cnt0, 32'd0);
    check("rst_after_ready", 32'(cmd_ready), 32'd1);
    tdi = $urandom;
    do_cmd("post_rst", 5'd15, 32'h0, tdi, tdi & len_mask(5'd15));

    check("tms_tdi_stable", stable_viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
